// File: rtl/cpu_pkg.sv
// Shared definitions for the command-address sequencer: the encoding of the
// single action taken per cycle and the default address width.
package cpu_pkg;

  // Default ROM command-address width.
  localparam int AW_DEFAULT = 13;

  // One action is selected per enabled cycle; HOLD also covers refused
  // call/ret (stack full/empty), which only raise the error flag.
  typedef enum logic [2:0] {
    ACT_HOLD = 3'd0,
    ACT_INC  = 3'd1,
    ACT_LOAD = 3'd2,
    ACT_CALL = 3'd3,
    ACT_RET  = 3'd4,
    ACT_BR   = 3'd5
  } act_e;

endpackage

// File: rtl/pc_seq_unit_if.sv
// Decoder-to-sequencer bundle: control strobes and targets going in,
// command address and stack status coming back.
interface pc_seq_unit_if #(
  parameter int AW = cpu_pkg::AW_DEFAULT
);

  logic          en;
  logic          load;
  logic [AW-1:0] ir_addr;
  logic          branch;
  logic [AW-1:0] br_off;
  logic          call;
  logic          ret;
  logic          err_clr;
  logic [AW-1:0] pc_addr;
  logic          stack_empty;
  logic          stack_full;
  logic          stack_err;

  // Instruction decoder side.
  modport master (
    output en, load, ir_addr, branch, br_off, call, ret, err_clr,
    input  pc_addr, stack_empty, stack_full, stack_err
  );

  // Sequencer side.
  modport slave (
    input  en, load, ir_addr, branch, br_off, call, ret, err_clr,
    output pc_addr, stack_empty, stack_full, stack_err
  );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. The fill level is an IW+1 bit count so that both
// "empty" (0) and "full" (DEPTH) are representable; the top entry sits at
// index count-1. Storage is not reset -- entries above the count are dead.
module pc_ret_stack #(
  parameter int AW    = cpu_pkg::AW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic          empty,
  output logic          full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [CW-1:0] count_reg;
  logic [AW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Refuse overflow/underflow here as well, so the count can never leave
  // 0..DEPTH whatever the caller does; push wins if both are requested.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign top_data = mem[IW'(count_reg - CW'(1))];

  // Fill-level counter, cleared asynchronously so a reset mid-call leaves
  // no partially pushed entry visible.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (do_push) begin
      count_reg <= count_reg + CW'(1);
    end else if (do_pop) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  // Entry write at the slot just above the current top.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[IW'(count_reg)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer feeding the ROM command address. Each enabled
// cycle performs exactly one of load > call > ret > branch > increment;
// all arithmetic wraps silently at AW bits.
module pc_seq_unit
  import cpu_pkg::*;
#(
  parameter int          AW        = AW_DEFAULT,
  parameter int          STEP      = 1,
  parameter int          DEPTH     = 4,
  parameter int unsigned RESET_VEC = 0
) (
  input logic          clock,
  input logic          rst,
  pc_seq_unit_if.slave bus
);

  act_e          act;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] stk_top;
  logic          stk_push;
  logic          stk_pop;
  logic          stk_empty;
  logic          stk_full;
  logic          err_set;
  logic          err_reg;

  // Sequential successor doubles as the return address pushed on call.
  assign pc_inc = pc_reg + AW'(STEP);

  // Priority decode: pick the single action for this cycle. A refused
  // call/ret degrades to HOLD and raises the error instead.
  always_comb begin
    act     = ACT_HOLD;
    err_set = 1'b0;
    if (bus.en) begin
      if (bus.load) begin
        act = ACT_LOAD;
      end else if (bus.call) begin
        if (stk_full) err_set = 1'b1;
        else          act     = ACT_CALL;
      end else if (bus.ret) begin
        if (stk_empty) err_set = 1'b1;
        else           act     = ACT_RET;
      end else if (bus.branch) begin
        act = ACT_BR;
      end else begin
        act = ACT_INC;
      end
    end
  end

  // Next pc and stack strobes for the chosen action.
  always_comb begin
    pc_next  = pc_reg;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (act)
      ACT_LOAD: pc_next = bus.ir_addr;
      ACT_CALL: begin
        pc_next  = bus.ir_addr;
        stk_push = 1'b1;
      end
      ACT_RET: begin
        pc_next = stk_top;
        stk_pop = 1'b1;
      end
      ACT_BR:   pc_next = pc_reg + bus.br_off;
      ACT_INC:  pc_next = pc_inc;
      default:  pc_next = pc_reg;
    endcase
  end

  // Program-counter register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) pc_reg <= AW'(RESET_VEC);
    else      pc_reg <= pc_next;
  end

  // Sticky stack error; a new error in the clearing cycle takes precedence.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)             err_reg <= 1'b0;
    else if (err_set)     err_reg <= 1'b1;
    else if (bus.err_clr) err_reg <= 1'b0;
  end

  pc_ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock     (clock),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  assign bus.pc_addr     = pc_reg;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_full  = stk_full;
  assign bus.stack_err   = err_reg;

endmodule
